// File: rtl/apb_requester.sv
// APB initiator: queues local read/write commands and runs two-phase APB transfers on pclk.
// Optional ACCESS-phase timeout is compiled in with `define APB_REQ_TIMEOUT_EN.
module apb_requester #(
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       pclk,
  input  logic       prstn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [3:0] paddr,
  output logic [7:0] pwdata,
  input  logic       pready,
  input  logic [7:0] prdata
);

  localparam int AW = $clog2(CMD_DEPTH);
  // An out-of-range configuration never raises cmd_ready.
  localparam bit CFG_OK = (CMD_DEPTH >= 2) && (CMD_DEPTH <= 8) &&
                          (TIMEOUT_CYCLES >= 1) && (TIMEOUT_CYCLES <= 255);

  typedef struct packed {
    logic       write;
    logic [3:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  cmd_t          mem [CMD_DEPTH];
  cmd_t          in_cmd, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, store, pop, load, bypass, done, abort;
  logic          rdy_en;

  assign in_cmd    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign full      = (count == (AW+1)'(CMD_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = rdy_en & ~full;
  assign push      = cmd_valid & cmd_ready;
  // A command arriving into an empty FIFO at a completing edge goes straight to the bus.
  assign store     = push & ~bypass;
  assign head      = bypass ? in_cmd : mem[rd_ptr];

  assign psel      = (state != IDLE);
  assign penable   = (state == ACCESS);

`ifdef APB_REQ_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt;

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn)                       tmo_cnt <= '0;
    else if (state == SETUP)          tmo_cnt <= '0;
    else if (state == ACCESS && !pready) tmo_cnt <= tmo_cnt + 8'd1;
  end
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    bypass    = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          state_nxt = SETUP;
          pop       = 1'b1;
          load      = 1'b1;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          done = 1'b1;
          if (!empty) begin
            state_nxt = SETUP;
            pop       = 1'b1;
            load      = 1'b1;
          end else if (push) begin
            state_nxt = SETUP;
            load      = 1'b1;
            bypass    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
`ifdef APB_REQ_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= CFG_OK;
    end
  end

  always_ff @(posedge pclk) begin
    if (store) mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
    end else if (load) begin
      pwrite <= head.write;
      paddr  <= head.addr;
      pwdata <= head.write ? head.wdata : 8'h00;
    end
  end

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done | abort;
      rsp_rdata <= (done && !pwrite) ? prdata : 8'h00;
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) rsp_err <= 1'b0;
    else        rsp_err <= abort;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/apb_requester.md
# apb_requester

APB initiator for the 4-bit-address, 8-bit-data peripheral bus. It accepts read and write commands from a local command port, buffers them in a small FIFO, and runs standard two-phase APB transfers (SETUP, ACCESS, wait states) against a single responder. It returns read data and completion status on a one-cycle response strobe. It sits between the local control logic and the register responder on pclk.

## Interface
- `CMD_DEPTH`, default 2: command FIFO entries; power of two, 2..8.
- `TIMEOUT_CYCLES`, default 15: maximum ACCESS cycles with `pready`=0 before abort. Used only when the timeout feature is compiled in; range 1..255.

Ports:
- `pclk`  in  1  bus clock; all logic is on the rising edge.
- `prstn`  in  1  reset: asynchronous, active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  4  target address.
- `cmd_wdata`  in  8  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle completion strobe.
- `rsp_rdata`  out  8  read data; 0 for writes and for aborts.
- `rsp_err`  out  1  1 = transfer aborted by timeout.
- `psel`, `penable`, `pwrite`  out  1  APB controls.
- `paddr`  out  4  APB address.
- `pwdata`  out  8  APB write data.
- `pready`  in  1  responder ready.
- `prdata`  in  8  responder read data.

## Operation
- A command is accepted at a rising edge where `cmd_valid` and `cmd_ready` are both 1. Each accepted command is pushed to the FIFO as {write, addr, wdata}.
- `cmd_ready` = !full. A push and a pop at the same edge when full is not allowed, because `cmd_ready` is 0.
- FSM states:
  - IDLE: `psel`=0, `penable`=0. Moves to SETUP when the FIFO is non-empty.
  - SETUP: pops the head entry into the output registers. `psel`=1, `penable`=0. Always moves to ACCESS.
  - ACCESS: `psel`=1, `penable`=1.
    - At an edge with `pready`=1, the transfer completes. The next state is SETUP if the FIFO is non-empty at that edge (including a command pushed at the same edge); otherwise IDLE.
    - With `pready`=0, the FSM stays in ACCESS (wait state).
- `paddr`, `pwdata` and `pwrite` are loaded on entry to SETUP. They are held stable through ACCESS and hold their last values in IDLE.
- For a write, `pwdata` is the command's `wdata`. For a read, `pwdata` is driven to 0.
- Completion of a read captures `prdata` into `rsp_rdata` at the completing edge.
- `rsp_valid` is 1 for exactly the cycle following the completing edge and has no backpressure.
- FIFO pointers wrap modulo `CMD_DEPTH`. Order is strict FIFO.
- Reset values: every output is 0, the FIFO is empty and the state is IDLE. `cmd_ready` goes to 1 once reset is released.
- Reset mid-transfer: the transfer and all queued commands are discarded, and no response is issued.

## Timing
- Minimum latency:
  - Accept at edge E0.
  - SETUP is visible after E1.
  - ACCESS is visible after E2.
  - The earliest completion is at E3, with `rsp_valid` high in the E3–E4 cycle.
- Each wait state adds one cycle.
- Back-to-back transfers: `psel` stays 1 and `penable` drops to 0 for exactly one SETUP cycle between transfers.
- `pready` is sampled only in ACCESS and is ignored in IDLE and SETUP.

## Configuration
- `APB_REQ_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to ACCESS and increments on each ACCESS edge with `pready`=0.
  - The edge at which the count reaches `TIMEOUT_CYCLES` aborts the transfer, with the FSM going to IDLE.
  - On abort, `rsp_valid`=1, `rsp_err`=1 and `rsp_rdata`=0 in the following cycle.
  - After an abort the FSM spends at least one IDLE cycle before starting the next queued command.
- `APB_REQ_TIMEOUT_EN` undefined:
  - There is no counter, and ACCESS waits indefinitely.
  - `rsp_err` is tied to 0.

## Test plan
- Reset then single write: write addr 0x3, data 0xA5, `pready`=1 throughout → one SETUP and one ACCESS cycle, with `paddr`=0x3 and `pwdata`=0xA5 in both. `rsp_valid` pulses once with `rsp_err`=0.
- Read with wait states: read addr 0x3 while the responder holds `pready`=0 for 3 cycles then returns 0xA5 → ACCESS lasts 4 cycles with controls stable, and the response has `rsp_rdata`=0xA5.
- FIFO full and back-to-back: push 3 commands with `CMD_DEPTH`=2 while the first is stalled → `cmd_ready`=0 after 2 queued entries. Transfers run in order, separated by single SETUP cycles, and produce 3 responses.
- Timeout (macro on, `TIMEOUT_CYCLES`=4): `pready` held at 0 → abort on the 4th wait edge, with `rsp_err`=1 and `rsp_rdata`=0. The next queued command follows after one IDLE cycle. With the macro off, ACCESS persists for 100 cycles.
- Reset mid-ACCESS: assert `prstn`=0 during ACCESS with 1 command queued → all outputs go to 0 immediately. After release, no `rsp_valid` is issued and `psel` stays 0.
